// File: rtl/execute_cycle.sv
`default_nettype none
// ============================================================================
// execute_cycle : RISC-V execute stage (forwarding muxes, ALU, branch target)
//                 and the E->M pipeline register.
// Revision 1.0
// ============================================================================
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic        BranchE,
    input  logic [1:0]  ResultSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [31:0] src_a;
    logic [31:0] src_b_fwd;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero_e;

    logic        reg_write_d,   reg_write_q;
    logic        mem_write_d,   mem_write_q;
    logic [1:0]  result_src_d,  result_src_q;
    logic [4:0]  rd_d,          rd_q;
    logic [31:0] alu_result_d,  alu_result_q;
    logic [31:0] write_data_d,  write_data_q;
    logic [31:0] pc_plus4_d,    pc_plus4_q;

    // Select 10 feeds back the registered ALU result, i.e. the previous instruction.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        src_b_fwd = RD2_E;
        case (ForwardBE)
            2'b01:   src_b_fwd = ResultW;
            2'b10:   src_b_fwd = alu_result_q;
            default: src_b_fwd = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    always_comb begin
        alu_result = 32'd0;
        case (ALUControlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_result = 32'd0;
        endcase
    end

    assign zero_e    = (alu_result == 32'd0);
    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = (BranchE & zero_e) | JumpE;

    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        alu_result_d = alu_result;
        // Stores always carry rs2, even though the ALU consumed the immediate.
        write_data_d = src_b_fwd;
        pc_plus4_d   = PCPlus4E;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            rd_q         <= 5'd0;
            alu_result_q <= 32'd0;
            write_data_q <= 32'd0;
            pc_plus4_q   <= 32'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// ============================================================================
// tb_execute_cycle : directed self-checking bench for execute_cycle.
// Revision 1.0
// ============================================================================
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE, PCPlus4E, ResultW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    task automatic clear_inputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
        ResultSrcE = 2'b00; ALUControlE = 3'b000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 0; PCPlus4E = 0; ResultW = 0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        RegWriteE = 1; MemWriteE = 1; RD_E = 5'd7; RD1_E = 32'h1234; PCPlus4E = 32'h44;
        step();
        tests++; if (RegWriteM !== 1'b0) begin fails++; $display("FAIL reset_regwrite: got %b expected 0", RegWriteM); end
        tests++; if (MemWriteM !== 1'b0) begin fails++; $display("FAIL reset_memwrite: got %b expected 0", MemWriteM); end
        tests++; if (ALUResultM !== 32'd0) begin fails++; $display("FAIL reset_aluresult: got %h expected 0", ALUResultM); end
        tests++; if (RD_M !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d expected 0", RD_M); end
        tests++; if (PCPlus4M !== 32'd0) begin fails++; $display("FAIL reset_pcplus4: got %h expected 0", PCPlus4M); end
        // Combinational outputs stay live during reset.
        PCE = 32'h100; Imm_Ext_E = 32'h4; JumpE = 1;
        #1;
        tests++; if (PCTargetE !== 32'h104) begin fails++; $display("FAIL reset_pctarget: got %h expected 00000104", PCTargetE); end
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL reset_pcsrc: got %b expected 1", PCSrcE); end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add_imm();
        clear_inputs();
        RD1_E = 32'd5; Imm_Ext_E = 32'd7; ALUSrcE = 1; ALUControlE = 3'b000;
        RD_E = 5'd3; RegWriteE = 1; RD2_E = 32'h55; ResultSrcE = 2'b10; PCPlus4E = 32'h208;
        #1;
        tests++; if (ALUResultM !== 32'd0) begin fails++; $display("FAIL add_imm_latency: got %h expected 0", ALUResultM); end
        step();
        tests++; if (ALUResultM !== 32'd12) begin fails++; $display("FAIL add_imm_result: got %h expected 0000000c", ALUResultM); end
        tests++; if (RD_M !== 5'd3) begin fails++; $display("FAIL add_imm_rd: got %0d expected 3", RD_M); end
        tests++; if (RegWriteM !== 1'b1) begin fails++; $display("FAIL add_imm_regwrite: got %b expected 1", RegWriteM); end
        tests++; if (WriteDataM !== 32'h55) begin fails++; $display("FAIL add_imm_writedata: got %h expected 00000055", WriteDataM); end
        tests++; if (ResultSrcM !== 2'b10) begin fails++; $display("FAIL add_imm_resultsrc: got %b expected 10", ResultSrcM); end
        tests++; if (PCPlus4M !== 32'h208) begin fails++; $display("FAIL add_imm_pcplus4: got %h expected 00000208", PCPlus4M); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RD1_E = 32'h10;
        step();
        tests++; if (ALUResultM !== 32'h10) begin fails++; $display("FAIL fwd_setup: got %h expected 00000010", ALUResultM); end
        clear_inputs();
        ForwardAE = 2'b10; RD1_E = 32'hDEAD; RD2_E = 32'd1; ALUControlE = 3'b001;
        step();
        tests++; if (ALUResultM !== 32'h0F) begin fails++; $display("FAIL fwd_a_from_m: got %h expected 0000000f", ALUResultM); end
        clear_inputs();
        ForwardBE = 2'b01; ResultW = 32'hAA; RD2_E = 32'h33; MemWriteE = 1;
        ALUSrcE = 1; Imm_Ext_E = 32'd4; RD1_E = 32'd0;
        step();
        tests++; if (WriteDataM !== 32'hAA) begin fails++; $display("FAIL fwd_b_writedata: got %h expected 000000aa", WriteDataM); end
        tests++; if (ALUResultM !== 32'd4) begin fails++; $display("FAIL fwd_b_imm_alu: got %h expected 00000004", ALUResultM); end
        tests++; if (MemWriteM !== 1'b1) begin fails++; $display("FAIL fwd_memwrite: got %b expected 1", MemWriteM); end
        clear_inputs();
        ForwardAE = 2'b01; ResultW = 32'h100; ForwardBE = 2'b10; RD2_E = 32'h9999; ALUControlE = 3'b000;
        step();
        tests++; if (ALUResultM !== 32'h104) begin fails++; $display("FAIL fwd_a_w_b_m: got %h expected 00000104", ALUResultM); end
        clear_inputs();
        ForwardAE = 2'b11; RD1_E = 32'h20; ResultW = 32'h777; RD2_E = 32'h3;
        step();
        tests++; if (ALUResultM !== 32'h23) begin fails++; $display("FAIL fwd_a_11: got %h expected 00000023", ALUResultM); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        RD1_E = 32'd100;
        step();
        // Each instruction adds 1 to the previous instruction's result.
        ForwardAE = 2'b10; ALUSrcE = 1; Imm_Ext_E = 32'd1; RD1_E = 32'd0;
        step();
        tests++; if (ALUResultM !== 32'd101) begin fails++; $display("FAIL b2b_first: got %0d expected 101", ALUResultM); end
        step();
        tests++; if (ALUResultM !== 32'd102) begin fails++; $display("FAIL b2b_second: got %0d expected 102", ALUResultM); end
        step();
        tests++; if (ALUResultM !== 32'd103) begin fails++; $display("FAIL b2b_third: got %0d expected 103", ALUResultM); end
    endtask

    task automatic test_branch();
        clear_inputs();
        BranchE = 1; RD1_E = 32'd9; RD2_E = 32'd9; ALUControlE = 3'b001;
        PCE = 32'h100; Imm_Ext_E = 32'hFFFFFFF0;
        #1;
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL branch_taken: got %b expected 1", PCSrcE); end
        tests++; if (PCTargetE !== 32'hF0) begin fails++; $display("FAIL branch_target: got %h expected 000000f0", PCTargetE); end
        RD2_E = 32'd8;
        #1;
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL branch_not_taken: got %b expected 0", PCSrcE); end
        RD2_E = 32'd9; BranchE = 0;
        #1;
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL branch_disabled: got %b expected 0", PCSrcE); end
        BranchE = 1; ALUControlE = 3'b110; RD1_E = 32'h5; RD2_E = 32'h3;
        #1;
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL branch_op110_zero: got %b expected 1", PCSrcE); end
    endtask

    task automatic test_alu_ops();
        clear_inputs();
        RD1_E = 32'hF0F0_00FF; RD2_E = 32'h0FF0_0F0F;
        ALUControlE = 3'b010; step();
        tests++; if (ALUResultM !== 32'h00F0_000F) begin fails++; $display("FAIL alu_and: got %h expected 00f0000f", ALUResultM); end
        ALUControlE = 3'b011; step();
        tests++; if (ALUResultM !== 32'hFFF0_0FFF) begin fails++; $display("FAIL alu_or: got %h expected fff00fff", ALUResultM); end
        ALUControlE = 3'b100; step();
        tests++; if (ALUResultM !== 32'hFF00_0FF0) begin fails++; $display("FAIL alu_xor: got %h expected ff000ff0", ALUResultM); end
        ALUControlE = 3'b111; step();
        tests++; if (ALUResultM !== 32'd0) begin fails++; $display("FAIL alu_op111: got %h expected 0", ALUResultM); end
        RD1_E = 32'hFFFFFFFF; RD2_E = 32'd1; ALUControlE = 3'b101; step();
        tests++; if (ALUResultM !== 32'd1) begin fails++; $display("FAIL slt_neg_lt_pos: got %h expected 1", ALUResultM); end
        RD1_E = 32'd1; RD2_E = 32'hFFFFFFFF; step();
        tests++; if (ALUResultM !== 32'd0) begin fails++; $display("FAIL slt_pos_lt_neg: got %h expected 0", ALUResultM); end
        RD1_E = 32'h8000_0000; RD2_E = 32'h7FFF_FFFF; step();
        tests++; if (ALUResultM !== 32'd1) begin fails++; $display("FAIL slt_extremes: got %h expected 1", ALUResultM); end
        RD1_E = 32'hFFFFFFFF; RD2_E = 32'd1; ALUControlE = 3'b000; JumpE = 1;
        #1;
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL jump_pcsrc: got %b expected 1", PCSrcE); end
        step();
        tests++; if (ALUResultM !== 32'd0) begin fails++; $display("FAIL add_wrap: got %h expected 0", ALUResultM); end
        RD1_E = 32'd0; RD2_E = 32'd1; ALUControlE = 3'b001; JumpE = 0; step();
        tests++; if (ALUResultM !== 32'hFFFFFFFF) begin fails++; $display("FAIL sub_wrap: got %h expected ffffffff", ALUResultM); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        RegWriteE = 1; RD_E = 5'd17; RD1_E = 32'h55; PCPlus4E = 32'h10;
        step();
        tests++; if (RD_M !== 5'd17) begin fails++; $display("FAIL midrst_pre: got %0d expected 17", RD_M); end
        #2;
        rst = 1'b0;
        #1;
        tests++; if (RegWriteM !== 1'b0) begin fails++; $display("FAIL midrst_regwrite: got %b expected 0", RegWriteM); end
        tests++; if (ALUResultM !== 32'd0) begin fails++; $display("FAIL midrst_aluresult: got %h expected 0", ALUResultM); end
        tests++; if (RD_M !== 5'd0) begin fails++; $display("FAIL midrst_rd: got %0d expected 0", RD_M); end
        step();
        tests++; if (RegWriteM !== 1'b0) begin fails++; $display("FAIL midrst_held: got %b expected 0", RegWriteM); end
        @(negedge clk);
        rst = 1'b1;
        step();
        tests++; if (RD_M !== 5'd17) begin fails++; $display("FAIL midrst_first_capture: got %0d expected 17", RD_M); end
        tests++; if (ALUResultM !== 32'h55) begin fails++; $display("FAIL midrst_first_alu: got %h expected 00000055", ALUResultM); end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_forwarding();
        test_back_to_back();
        test_branch();
        test_alu_ops();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
